// File: rtl/isa_pkg.sv
// RV32I encoding constants, format codes and the decoded field bundle shared by
// the instruction encoder and its round-trip checkers.
package isa_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_OP     = 7'h33;

  // fmt stays a raw 3-bit code so the invalid values 6 and 7 can be carried
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } bundle_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: scatters the immediate into its format-specific
// bit positions and flags bundles whose immediate cannot be encoded.
module imm_pack
  import isa_pkg::*;
(
  input  bundle_t     i_fields,
  output logic [31:0] o_inst,
  output logic        o_illegal
);

  logic [31:0] w_imm;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;
  logic [31:0] w_inst;
  logic        w_illegal;

  assign w_imm = i_fields.imm;

  // A value fits an N-bit signed field when all bits above N-1 match the sign
  assign w_fit12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
  assign w_fit13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
  assign w_fit21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);

  always_comb begin
    w_inst    = NOP;
    w_illegal = 1'b0;
    case (fmt_e'(i_fields.fmt))
      FMT_R: w_inst = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                       i_fields.funct3, i_fields.rd, i_fields.opcode};
      FMT_I: begin
        w_illegal = !w_fit12;
        w_inst    = {w_imm[11:0], i_fields.rs1, i_fields.funct3,
                     i_fields.rd, i_fields.opcode};
      end
      FMT_S: begin
        w_illegal = !w_fit12;
        w_inst    = {w_imm[11:5], i_fields.rs2, i_fields.rs1,
                     i_fields.funct3, w_imm[4:0], i_fields.opcode};
      end
      FMT_B: begin
        w_illegal = !w_fit13 || w_imm[0];
        w_inst    = {w_imm[12], w_imm[10:5], i_fields.rs2, i_fields.rs1,
                     i_fields.funct3, w_imm[4:1], w_imm[11], i_fields.opcode};
      end
      FMT_U: begin
        w_illegal = |w_imm[11:0];
        w_inst    = {w_imm[31:12], i_fields.rd, i_fields.opcode};
      end
      FMT_J: begin
        w_illegal = !w_fit21 || w_imm[0];
        w_inst    = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                     i_fields.rd, i_fields.opcode};
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) w_inst = NOP;
  end

  assign o_inst    = w_inst;
  assign o_illegal = w_illegal;

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: two-stage valid/ready pipeline that packs decoded
// fields into instruction words tagged with sequential memory addresses.
module inst_encoder
  import isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

  function automatic logic [31:0] next_addr(input logic [31:0] a);
    return (a == LAST_ADDR) ? BASE_ADDR : a + 32'd4;
  endfunction

  bundle_t     r_s1;
  logic        r_s1_valid;
  logic        r_s2_valid;
  logic [31:0] r_inst;
  logic [31:0] r_addr;
  logic        r_err;
  logic [31:0] r_next_addr;
  logic [7:0]  r_err_cnt;

  bundle_t     w_bundle;
  logic        w_s2_adv;
  logic        w_load;
  logic        w_s1_take;
  logic [31:0] w_load_addr;
  logic [31:0] w_inst;
  logic        w_illegal;

  assign w_bundle = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                      rs2: in_rs2, funct3: in_funct3, funct7: in_funct7,
                      imm: in_imm};

  assign w_s2_adv    = !r_s2_valid || out_ready;
  assign w_load      = w_s2_adv && r_s1_valid;
  assign in_ready    = !r_s1_valid || w_s2_adv;
  assign w_s1_take   = in_valid && in_ready;
  // A word entering S2 alongside clear is the first of the new address window
  assign w_load_addr = clear ? BASE_ADDR : r_next_addr;

  imm_pack u_imm_pack (
    .i_fields  (r_s1),
    .o_inst    (w_inst),
    .o_illegal (w_illegal)
  );

  // S1: raw field bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_s1_take) r_s1 <= w_bundle;
    end
  end

  // S2: encoded word, error flag and assigned address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_inst     <= 32'h0;
      r_addr     <= BASE_ADDR;
      r_err      <= 1'b0;
    end else begin
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_load) begin
        r_inst <= w_inst;
        r_err  <= w_illegal;
        r_addr <= w_load_addr;
      end
    end
  end

  // Address of the next word to enter S2 and the rejected-bundle count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_addr <= BASE_ADDR;
      r_err_cnt   <= 8'h0;
    end else begin
      if (w_load)     r_next_addr <= next_addr(w_load_addr);
      else if (clear) r_next_addr <= BASE_ADDR;
      if (clear)                                            r_err_cnt <= 8'h0;
      else if (w_load && w_illegal && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_inst  = r_inst;
  assign out_addr  = r_addr;
  assign out_err   = r_err;
  assign err_cnt   = r_err_cnt;

endmodule
